ysyx_24080006_csr_seq: RTL and testbench
========================================

Name: ysyx_24080006_csr_seq

Overview:
- Initiator side of the CSR-file interface. Accepts one decoded SYSTEM instruction from decode over a valid/ready handshake: CSRRW, CSRRS, CSRRC (register or immediate form), ECALL or MRET.
- Sequences the CSR file's enable, op, name, wdata, ecall and mret lines.
- Returns the old CSR value to writeback. Emits a one-cycle PC redirect for traps and returns.

Parameters:
- None. All widths are fixed by the CSR-file interface.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept
- in_op  in  3  0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET; 5-7 illegal
- in_csr  in  12  CSR address
- in_src  in  32  rs1 value or zero-extended zimm (already selected)
- in_src_is_zero  in  1  rs1 index==x0, or zimm==0
- in_rd  in  5  destination register
- in_pc  in  32  PC of the instruction
- csr_enable  out  1  to CSR file
- csr_op  out  2  0=READ, 1=WRITE, 2=SET, 3=CLEAR
- csr_name  out  12  to CSR file
- csr_wdata  out  32  to CSR file
- csr_pc  out  32  to CSR file (mepc source)
- ecall  out  1  to CSR file
- mret  out  1  to CSR file
- csr_rdata  in  32  combinational read from CSR file
- wb_valid  out  1  result ready
- wb_ready  in  1  writeback accepts
- wb_rd  out  5  destination register
- wb_data  out  32  old CSR value
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  redirect target
- err  out  1  one-cycle pulse on an illegal in_op

Behaviour:
- Reset, asynchronous: state=IDLE. All latched fields, wb_data and redirect_pc clear to 0. Every output is 0, including in_ready while reset is high.
- in_ready=1 only in IDLE. A handshake is in_valid&in_ready; it latches op, csr, src, src_is_zero, rd and pc.
- Every CSR-file output is 0 outside the states listed below.
- IDLE on handshake:
  - op 0-2 -> ACCESS.
  - op 3 -> TRAP.
  - op 4 -> RET.
  - op 5-7 -> err=1 next cycle, stay IDLE, no CSR activity.
- ACCESS (one cycle):
  - Drive csr_enable=1, csr_name=csr, csr_wdata=src.
  - csr_op: CSRRW->WRITE; CSRRS->SET; CSRRC->CLEAR.
  - If src_is_zero for CSRRS/CSRRC, drive READ instead, so no write occurs.
  - CSRRW always writes, even when src_is_zero.
  - Capture csr_rdata (pre-write value) into wb_data. The CSR file commits at the end of this cycle. -> WB.
- WB: wb_valid=1, wb_rd and wb_data held stable until wb_ready. On wb_valid&wb_ready -> IDLE. rd=0 is still presented.
- TRAP (one cycle): ecall=1, csr_pc=latched pc. The CSR file updates mepc, mcause=11 and mstatus at the edge. -> VEC.
- VEC (one cycle): csr_name=0x305 (mtvec), csr_enable=0. Capture csr_rdata into redirect_pc. -> REDIRECT.
- RET (one cycle): csr_name=0x341 (mepc), mret=1. Capture csr_rdata into redirect_pc. -> REDIRECT.
- REDIRECT: redirect_valid=1 for exactly one cycle, with no back-pressure. -> IDLE.
- Latency, handshake at edge 0:
  - CSR op: wb_valid in cycle 2.
  - MRET: redirect_valid in cycle 2.
  - ECALL: redirect_valid in cycle 3.
- ecall and mret are never both high. csr_enable is never high together with either of them.
- Reset mid-operation: the instruction is abandoned. No further CSR-file strobes, no wb, no redirect.

Optional Feature:
- Macro: CSR_SEQ_WB_BYPASS_EN.
- With it, in ACCESS: wb_valid=1, wb_data=csr_rdata combinationally, wb_rd=rd.
  - If wb_ready=1, go -> IDLE. CSR-op latency becomes 1 cycle.
  - Otherwise capture csr_rdata and go -> WB as normal.
  - The CSR write still happens exactly once.
- Without it: ACCESS never asserts wb_valid and always goes through WB.

Test Plan:
1. mtvec=0x80000100. CSRRW csr=0x305, src=0x80000200, rd=5, wb_ready=1 -> wb_valid cycle 2, wb_rd=5, wb_data=0x80000100. A later read of mtvec returns 0x80000200.
2. mstatus=0x1800. CSRRS csr=0x300, src=0x8, src_is_zero=0 -> wb_data=0x1800, mstatus=0x1808. Repeat with src_is_zero=1 -> csr_op=READ in ACCESS, mstatus unchanged.
3. ECALL, pc=0x80000040, mtvec=0x80000100 -> ecall=1 cycle 1 with csr_pc=0x80000040; redirect_valid cycle 3 with redirect_pc=0x80000100. mepc=0x80000040, mcause=11.
4. MRET, mepc=0x80000044 -> mret=1 cycle 1, redirect_valid cycle 2 with redirect_pc=0x80000044, in_ready=1 cycle 3.
5. CSRRC csr=0xB00 with wb_ready held 0 for 4 cycles -> wb_valid/wb_data stable for all 4; in_ready=0 throughout; single write strobe only.
6. Assert reset in TRAP or VEC; separately, in_op=6 -> after reset no redirect and all outputs 0; in_op=6 gives err one-cycle pulse, no csr_enable, in_ready stays 1.

Source files
------------

// File: rtl/ysyx_24080006_csr_seq.sv
// ysyx_24080006_csr_seq: drives one decoded SYSTEM instruction onto the CSR-file interface.
// Optional CSR_SEQ_WB_BYPASS_EN: return the old CSR value in the ACCESS cycle when writeback is ready.
module ysyx_24080006_csr_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [11:0] in_csr,
  input  logic [31:0] in_src,
  input  logic        in_src_is_zero,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  output logic        csr_enable,
  output logic [1:0]  csr_op,
  output logic [11:0] csr_name,
  output logic [31:0] csr_wdata,
  output logic [31:0] csr_pc,
  output logic        ecall,
  output logic        mret,
  input  logic [31:0] csr_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WB,
    S_TRAP,
    S_VEC,
    S_RET,
    S_REDIRECT
  } state_e;

  localparam logic [2:0]  OP_CSRRW  = 3'd0;
  localparam logic [2:0]  OP_CSRRS  = 3'd1;
  localparam logic [2:0]  OP_CSRRC  = 3'd2;
  localparam logic [2:0]  OP_ECALL  = 3'd3;
  localparam logic [2:0]  OP_MRET   = 3'd4;

  localparam logic [1:0]  CSR_READ  = 2'd0;
  localparam logic [1:0]  CSR_WRITE = 2'd1;
  localparam logic [1:0]  CSR_SET   = 2'd2;
  localparam logic [1:0]  CSR_CLEAR = 2'd3;

  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC  = 12'h341;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] csr_q, csr_d;
  logic [31:0] src_q, src_d;
  logic        zero_q, zero_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        err_q, err_d;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    csr_d          = csr_q;
    src_d          = src_q;
    zero_d         = zero_q;
    rd_d           = rd_q;
    pc_d           = pc_q;
    wb_data_d      = wb_data_q;
    redirect_pc_d  = redirect_pc_q;
    err_d          = 1'b0;

    in_ready       = (state_q == S_IDLE) && !reset;
    csr_enable     = 1'b0;
    csr_op         = CSR_READ;
    csr_name       = 12'h000;
    csr_wdata      = 32'h0;
    csr_pc         = 32'h0;
    ecall          = 1'b0;
    mret           = 1'b0;
    wb_valid       = 1'b0;
    wb_rd          = rd_q;
    wb_data        = wb_data_q;
    redirect_valid = 1'b0;
    redirect_pc    = redirect_pc_q;
    err            = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d   = in_op;
          csr_d  = in_csr;
          src_d  = in_src;
          zero_d = in_src_is_zero;
          rd_d   = in_rd;
          pc_d   = in_pc;
          case (in_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_ACCESS;
            OP_ECALL:                     state_d = S_TRAP;
            OP_MRET:                      state_d = S_RET;
            default:                      err_d   = 1'b1;
          endcase
        end
      end

      S_ACCESS: begin
        csr_enable = 1'b1;
        csr_name   = csr_q;
        csr_wdata  = src_q;
        // Set/clear with a zero operand degrade to a pure read so no side-effecting write reaches the CSR.
        case (op_q)
          OP_CSRRW: csr_op = CSR_WRITE;
          OP_CSRRS: csr_op = zero_q ? CSR_READ : CSR_SET;
          OP_CSRRC: csr_op = zero_q ? CSR_READ : CSR_CLEAR;
          default:  csr_op = CSR_READ;
        endcase
        wb_data_d = csr_rdata;
        state_d   = S_WB;
`ifdef CSR_SEQ_WB_BYPASS_EN
        wb_valid = 1'b1;
        wb_data  = csr_rdata;
        if (wb_ready) state_d = S_IDLE;
`endif
      end

      S_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = S_IDLE;
      end

      S_TRAP: begin
        ecall   = 1'b1;
        csr_pc  = pc_q;
        state_d = S_VEC;
      end

      S_VEC: begin
        // mtvec is read after the trap edge; the CSR file reads combinationally without enable.
        csr_name      = CSR_MTVEC;
        redirect_pc_d = csr_rdata;
        state_d       = S_REDIRECT;
      end

      S_RET: begin
        csr_name      = CSR_MEPC;
        mret          = 1'b1;
        redirect_pc_d = csr_rdata;
        state_d       = S_REDIRECT;
      end

      S_REDIRECT: begin
        redirect_valid = 1'b1;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an asynchronous reset that abandons any instruction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= 3'd0;
      csr_q         <= 12'h000;
      src_q         <= 32'h0;
      zero_q        <= 1'b0;
      rd_q          <= 5'd0;
      pc_q          <= 32'h0;
      wb_data_q     <= 32'h0;
      redirect_pc_q <= 32'h0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      csr_q         <= csr_d;
      src_q         <= src_d;
      zero_q        <= zero_d;
      rd_q          <= rd_d;
      pc_q          <= pc_d;
      wb_data_q     <= wb_data_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_csr_seq.sv
// Scoreboard bench for ysyx_24080006_csr_seq: mock CSR file, issue-time reference model, decoupled monitor.
module tb_ysyx_24080006_csr_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [11:0] in_csr = 12'h0;
  logic [31:0] in_src = 32'h0;
  logic        in_src_is_zero = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_pc = 32'h0;
  logic        csr_enable;
  logic [1:0]  csr_op;
  logic [11:0] csr_name;
  logic [31:0] csr_wdata;
  logic [31:0] csr_pc;
  logic        ecall;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        err;

  always #5 clock = ~clock;

  ysyx_24080006_csr_seq dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_csr(in_csr),
    .in_src(in_src), .in_src_is_zero(in_src_is_zero), .in_rd(in_rd), .in_pc(in_pc),
    .csr_enable(csr_enable), .csr_op(csr_op), .csr_name(csr_name), .csr_wdata(csr_wdata),
    .csr_pc(csr_pc), .ecall(ecall), .mret(mret), .csr_rdata(csr_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .err(err)
  );

`ifdef CSR_SEQ_WB_BYPASS_EN
  localparam int CSR_LAT = 1;
`else
  localparam int CSR_LAT = 2;
`endif

  // Maps a CSR address onto its mock-file entry (mstatus, mtvec, mscratch, mepc, mcause, mcycle); unknown addresses map to 7.
  function automatic logic [2:0] csr_idx(input logic [11:0] a);
    case (a)
      12'h300: return 3'd0;
      12'h305: return 3'd1;
      12'h340: return 3'd2;
      12'h341: return 3'd3;
      12'h342: return 3'd4;
      12'hB00: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // ---------------- mock CSR file ----------------
  logic [31:0] env_r [8];
  logic        env_load = 1'b0;
  logic [11:0] env_addr = 12'h0;
  logic [31:0] env_val = 32'h0;
  logic [2:0]  k_name, k_env;

  assign k_name    = csr_idx(csr_name);
  assign k_env     = csr_idx(env_addr);
  assign csr_rdata = (k_name != 3'd7) ? env_r[k_name] : 32'h0;

  always @(posedge clock) begin
    if (env_load) begin
      if (k_env != 3'd7) env_r[k_env] <= env_val;
    end else if (csr_enable) begin
      if (k_name != 3'd7) begin
        case (csr_op)
          2'd1:    env_r[k_name] <= csr_wdata;
          2'd2:    env_r[k_name] <= env_r[k_name] | csr_wdata;
          2'd3:    env_r[k_name] <= env_r[k_name] & ~csr_wdata;
          default: ;
        endcase
      end
    end else if (ecall) begin
      env_r[3] <= csr_pc;
      env_r[4] <= 32'd11;
      env_r[0] <= {env_r[0][31:13], 2'b11, env_r[0][10:8], env_r[0][3], env_r[0][6:4], 1'b0, env_r[0][2:0]};
    end else if (mret) begin
      env_r[0] <= {env_r[0][31:13], 2'b00, env_r[0][10:8], 1'b1, env_r[0][6:4], env_r[0][7], env_r[0][2:0]};
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef enum int {K_WB, K_RED, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [11:0] csr;
    logic [31:0] src;
    logic [1:0]  cop;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    int          hs;
    int          lat;
    int          n_wr, n_en, n_ec, n_mr;
  } item_t;

  item_t       exq[$];
  logic [31:0] mdl [8];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c_wr = 0, c_en = 0, c_ec = 0, c_mr = 0;
  int red_cnt = 0;
  bit first_seen = 1'b0;
  int wb_mode = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic item_t model_step(input logic [2:0] op, input logic [11:0] csr,
                                       input logic [31:0] src, input logic zero,
                                       input logic [4:0] rd, input logic [31:0] pc, input int hs);
    item_t       t;
    logic [2:0]  k;
    logic [31:0] old, m;
    t.kind = K_ERR; t.csr = csr; t.src = src; t.cop = 2'd0; t.rd = rd; t.data = 32'h0;
    t.pc = pc; t.hs = hs; t.lat = 1; t.n_wr = 0; t.n_en = 0; t.n_ec = 0; t.n_mr = 0;
    k   = csr_idx(csr);
    old = (k != 3'd7) ? mdl[k] : 32'h0;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        t.kind = K_WB; t.data = old; t.lat = CSR_LAT; t.n_en = 1;
        if (op == 3'd0)  begin t.cop = 2'd1; m = src; end
        else if (zero)   begin t.cop = 2'd0; m = old; end
        else if (op == 3'd1) begin t.cop = 2'd2; m = old | src; end
        else             begin t.cop = 2'd3; m = old & ~src; end
        t.n_wr = (t.cop != 2'd0) ? 1 : 0;
        if (k != 3'd7) mdl[k] = m;
      end
      3'd3: begin
        t.kind = K_RED; t.data = mdl[1]; t.lat = 3; t.n_ec = 1;
        m = mdl[0];
        mdl[3] = pc;
        mdl[4] = 32'd11;
        mdl[0] = (m & ~32'h1888) | 32'h1800 | (m[3] ? 32'h80 : 32'h0);
      end
      3'd4: begin
        t.kind = K_RED; t.data = mdl[3]; t.lat = 2; t.n_mr = 1;
        m = mdl[0];
        mdl[0] = (m & ~32'h1888) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
      end
      default: ;
    endcase
    return t;
  endfunction

  task automatic pop_check(input item_t it);
    check("strobe_writes", c_wr, it.n_wr);
    check("strobe_enables", c_en, it.n_en);
    check("strobe_ecall", c_ec, it.n_ec);
    check("strobe_mret", c_mr, it.n_mr);
    void'(exq.pop_front());
    c_wr = 0; c_en = 0; c_ec = 0; c_mr = 0;
    first_seen = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    item_t it;
    if (reset) begin
      check("reset_outputs_zero",
            {31'h0, |{in_ready, csr_enable, csr_op, csr_name, csr_wdata, csr_pc, ecall, mret,
                      wb_valid, wb_rd, wb_data, redirect_valid, redirect_pc, err}}, 32'h0);
      c_wr = 0; c_en = 0; c_ec = 0; c_mr = 0;
      first_seen = 1'b0;
    end else begin
      c_wr += (csr_enable && csr_op != 2'd0) ? 1 : 0;
      c_en += csr_enable ? 1 : 0;
      c_ec += ecall ? 1 : 0;
      c_mr += mret ? 1 : 0;
      red_cnt += redirect_valid ? 1 : 0;
      check("strobe_exclusive", {30'h0, ecall & mret, csr_enable & (ecall | mret)}, 32'h0);
      if (csr_enable || ecall || mret || wb_valid || redirect_valid || err) begin
        if (exq.size() == 0) begin
          check("unexpected_output", {26'h0, wb_valid, redirect_valid, err, csr_enable, ecall, mret}, 32'h0);
        end else begin
          it = exq[0];
          if (csr_enable) begin
            check("access_name", {20'h0, csr_name}, {20'h0, it.csr});
            check("access_wdata", csr_wdata, it.src);
            check("access_op", {30'h0, csr_op}, {30'h0, it.cop});
            check("access_cycle", cyc - it.hs, 1);
          end
          if (ecall) begin
            check("ecall_pc", csr_pc, it.pc);
            check("ecall_cycle", cyc - it.hs, 1);
          end
          if (mret) check("mret_cycle", cyc - it.hs, 1);
          if (wb_valid) begin
            check("wb_kind", int'(it.kind), int'(K_WB));
            check("wb_rd", {27'h0, wb_rd}, {27'h0, it.rd});
            check("wb_data", wb_data, it.data);
            if (!first_seen) check("wb_latency", cyc - it.hs, it.lat);
            first_seen = 1'b1;
            if (wb_ready) pop_check(it);
          end else if (redirect_valid) begin
            check("redirect_kind", int'(it.kind), int'(K_RED));
            check("redirect_pc", redirect_pc, it.data);
            check("redirect_latency", cyc - it.hs, it.lat);
            pop_check(it);
          end else if (err) begin
            check("err_kind", int'(it.kind), int'(K_ERR));
            check("err_latency", cyc - it.hs, it.lat);
            pop_check(it);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial forever begin
    @(posedge clock);
    #1;
    case (wb_mode)
      0:       wb_ready = 1'b1;
      1:       wb_ready = ($urandom_range(0, 2) != 0);
      default: wb_ready = 1'b0;
    endcase
  end

  task automatic poke(input logic [11:0] addr, input logic [31:0] val);
    @(posedge clock);
    #1;
    env_load = 1'b1; env_addr = addr; env_val = val;
    @(posedge clock);
    #1;
    env_load = 1'b0;
    mdl[csr_idx(addr)] = val;
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                       input logic zero, input logic [4:0] rd, input logic [31:0] pc,
                       input bit push, output int hs);
    int guard = 0;
    hs = -1;
    @(negedge clock);
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      check("issue_ready_timeout", {31'h0, in_ready}, 32'h1);
      return;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b1; in_op = op; in_csr = csr; in_src = src;
    in_src_is_zero = zero; in_rd = rd; in_pc = pc;
    @(posedge clock);
    hs = cyc;
    if (push) exq.push_back(model_step(op, csr, src, zero, rd, pc, hs));
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [11:0] csr_list [7];
  initial begin
    int          hs, rc0, r, g;
    logic [2:0]  op;
    logic        zero;
    logic [31:0] src;
    csr_list = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'h7C0};
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 6; i++) poke(csr_list[i], 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
    check("post_reset_idle_outputs",
          {25'h0, csr_enable, ecall, mret, wb_valid, redirect_valid, err, |wb_data | |redirect_pc}, 32'h0);

    // CSRRW mtvec, then read it back
    poke(12'h305, 32'h8000_0100);
    issue(3'd0, 12'h305, 32'h8000_0200, 1'b0, 5'd5, 32'h8000_0000, 1'b1, hs);
    issue(3'd1, 12'h305, 32'h0, 1'b1, 5'd6, 32'h8000_0004, 1'b1, hs);
    poke(12'h305, 32'h8000_0100);

    // CSRRS mstatus, then the same with a zero operand
    poke(12'h300, 32'h0000_1800);
    issue(3'd1, 12'h300, 32'h8, 1'b0, 5'd7, 32'h8000_0008, 1'b1, hs);
    issue(3'd1, 12'h300, 32'h8, 1'b1, 5'd8, 32'h8000_000C, 1'b1, hs);
    issue(3'd0, 12'h340, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'h8000_0010, 1'b1, hs);

    // ECALL
    issue(3'd3, 12'h000, 32'h0, 1'b0, 5'd0, 32'h8000_0040, 1'b1, hs);

    // MRET, in_ready back in cycle 3
    poke(12'h341, 32'h8000_0044);
    issue(3'd4, 12'h000, 32'h0, 1'b0, 5'd0, 32'h8000_0100, 1'b1, hs);
    while (cyc < hs + 3) @(negedge clock);
    check("mret_in_ready_cycle3", {31'h0, in_ready}, 32'h1);

    // CSRRC with writeback stalled for 4 cycles
    poke(12'hB00, 32'hFFFF_0F0F);
    wb_mode = 2;
    issue(3'd2, 12'hB00, 32'h0000_00FF, 1'b0, 5'd9, 32'h8000_0050, 1'b1, hs);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_in_ready_low", {31'h0, in_ready}, 32'h0);
    end
    wb_mode = 0;

    // Reset during TRAP: nothing of the ECALL may reach the CSR file
    issue(3'd3, 12'h000, 32'h0, 1'b0, 5'd0, 32'h8000_0060, 1'b0, hs);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rc0 = red_cnt;
    repeat (6) @(negedge clock);
    check("no_redirect_after_trap_reset", red_cnt - rc0, 0);

    // Reset during VEC: the trap already committed, the redirect must not appear
    issue(3'd3, 12'h000, 32'h0, 1'b0, 5'd0, 32'h8000_0070, 1'b1, hs);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exq.delete();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rc0 = red_cnt;
    repeat (6) @(negedge clock);
    check("no_redirect_after_vec_reset", red_cnt - rc0, 0);

    // Illegal op
    issue(3'd6, 12'h300, 32'h1, 1'b0, 5'd3, 32'h8000_0080, 1'b1, hs);
    @(negedge clock);
    check("illegal_in_ready", {31'h0, in_ready}, 32'h1);

    // Randomized traffic with random writeback back-pressure
    wb_mode = 1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 15);
      if (r < 4)       op = 3'd0;
      else if (r < 8)  op = 3'd1;
      else if (r < 12) op = 3'd2;
      else if (r == 12) op = 3'd3;
      else if (r == 13) op = 3'd4;
      else             op = 3'($urandom_range(5, 7));
      zero = ($urandom_range(0, 3) == 0);
      src  = (zero && $urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      issue(op, csr_list[$urandom_range(0, 6)], src, zero, 5'($urandom_range(0, 31)),
            $urandom & 32'hFFFF_FFFC, 1'b1, hs);
    end

    g = 0;
    while (exq.size() != 0 && g < 300) begin
      @(negedge clock);
      g++;
    end
    check("drain_queue", exq.size(), 0);
    for (int i = 0; i < 6; i++) check($sformatf("csr_state_%0d", i), env_r[3'(i)], mdl[3'(i)]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
